usb_rx_deserializer: RTL and testbench

Parametrised serial-to-parallel converter for the USB receive path. It takes NRZI-decoded bits, one per `shift_enable` strobe, and removes USB bit-stuffing. It assembles the bits into `WIDTH`-bit words in a configurable bit order and presents each word on a one-deep valid/ready output register. It sits between the NRZI decoder and the packet/PID logic, and reports stuffing violations and output overflow.

---
 rtl/usb_rx_deserializer.sv | 99 +++++++++
 tb/tb_usb_rx_deserializer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_deserializer.sv
// USB receive deserializer: bit-stuff removal, WIDTH-bit word assembly, one-deep valid/ready output.
// Define USB_RX_BITSTUFF_EN to enable stuff-bit removal and stuff violation detection.
module usb_rx_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             shift_enable,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             stuff_err,
    output logic             overflow,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             strobe;
    logic             is_stuff;
    logic             stuff_viol;
    logic             accept;
    logic             complete;
    logic             take;
    logic             load;

    assign strobe = shift_enable & ~clear;

`ifdef USB_RX_BITSTUFF_EN
    logic [2:0] ones;

    // Ones run spans word boundaries; it never exceeds 6 because the next strobe is a stuff bit.
    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            ones <= '0;
        end else if (shift_enable) begin
            if (is_stuff || !serial_in) begin
                ones <= '0;
            end else begin
                ones <= ones + 3'd1;
            end
        end
    end

    assign is_stuff   = strobe && (ones == 3'd6);
    assign stuff_viol = is_stuff & serial_in;
`else
    assign is_stuff   = 1'b0;
    assign stuff_viol = 1'b0;
`endif

    assign shifted  = LSB_FIRST ? {serial_in, shreg[WIDTH-1:1]}
                                : {shreg[WIDTH-2:0], serial_in};
    assign accept   = strobe & ~is_stuff;
    assign complete = accept && (bit_cnt == CW'(WIDTH - 1));
    assign take     = data_valid & data_ready;
    assign load     = complete & (~data_valid | data_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            stuff_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            stuff_err <= stuff_viol;
            if (take) begin
                data_valid <= 1'b0;
            end
            if (load) begin
                data_out   <= shifted;
                data_valid <= 1'b1;
            end
            if (clear) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (complete && !load) begin
                    overflow <= 1'b1;
                end
                if (accept) begin
                    shreg   <= shifted;
                    bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
                end else if (stuff_viol) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Directed bench for usb_rx_deserializer: LSB and MSB instances driven by one shared bit stream.
module tb_usb_rx_deserializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       clear = 1'b0;
    logic       shift_enable = 1'b0;
    logic       serial_in = 1'b0;
    logic       data_ready = 1'b0;

    logic [7:0] data_lsb, data_msb;
    logic       valid_lsb, valid_msb;
    logic       serr_lsb, serr_msb;
    logic       ovf_lsb, ovf_msb;
    logic [2:0] cnt_lsb, cnt_msb;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    usb_rx_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .CLK(CLK), .RST(RST), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .data_out(data_lsb), .data_valid(valid_lsb),
        .data_ready(data_ready), .stuff_err(serr_lsb), .overflow(ovf_lsb),
        .bit_cnt(cnt_lsb)
    );

    usb_rx_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .CLK(CLK), .RST(RST), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .data_out(data_msb), .data_valid(valid_msb),
        .data_ready(data_ready), .stuff_err(serr_msb), .overflow(ovf_msb),
        .bit_cnt(cnt_msb)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic b);
        shift_enable = 1'b1;
        serial_in    = b;
        tick();
        shift_enable = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) strobe(w[i]);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_both(input string tag, input logic [7:0] exp_lsb, input logic [7:0] exp_msb);
        check({tag, "_valid_lsb"}, 64'(valid_lsb), 64'd1);
        check({tag, "_valid_msb"}, 64'(valid_msb), 64'd1);
        check({tag, "_data_lsb"}, 64'(data_lsb), 64'(exp_lsb));
        check({tag, "_data_msb"}, 64'(data_msb), 64'(exp_msb));
    endtask

    initial begin
        logic [7:0] stream;

        tick();
        tick();
        RST = 1'b0;
        check("rst_data", 64'(data_lsb), 64'h0);
        check("rst_valid", 64'(valid_lsb), 64'h0);
        check("rst_cnt", 64'(cnt_lsb), 64'h0);
        check("rst_ovf", 64'(ovf_lsb), 64'h0);
        check("rst_serr", 64'(serr_lsb), 64'h0);

        // Stream 1,0,1,1,0,0,1,0: LSB order gives 0x4D, MSB order 0xB2.
        data_ready = 1'b1;
        stream = 8'b0100_1101;
        for (int i = 0; i < 7; i++) strobe(stream[i]);
        check("order_cnt7", 64'(cnt_lsb), 64'd7);
        check("order_novalid", 64'(valid_lsb), 64'd0);
        strobe(stream[7]);
        check_both("order", 8'h4D, 8'hB2);
        check("order_cnt_wrap", 64'(cnt_lsb), 64'd0);
        tick();
        check("order_valid_1cyc", 64'(valid_lsb), 64'd0);

        for (int i = 0; i < 6; i++) strobe(1'b1);
        check("ones6_cnt", 64'(cnt_lsb), 64'd6);
`ifdef USB_RX_BITSTUFF_EN
        strobe(1'b0);
        check("stuff0_cnt", 64'(cnt_lsb), 64'd6);
        check("stuff0_serr", 64'(serr_lsb), 64'd0);
        strobe(1'b1);
        strobe(1'b1);
        check_both("stuff0", 8'hFF, 8'hFF);
`else
        strobe(1'b0);
        check("nostuff_cnt", 64'(cnt_lsb), 64'd7);
        check("nostuff_serr", 64'(serr_lsb), 64'd0);
        strobe(1'b1);
        check_both("nostuff", 8'hBF, 8'hFD);
`endif
        pulse_clear();

        for (int i = 0; i < 6; i++) strobe(1'b1);
`ifdef USB_RX_BITSTUFF_EN
        strobe(1'b1);
        check("viol_serr", 64'(serr_lsb), 64'd1);
        check("viol_serr_msb", 64'(serr_msb), 64'd1);
        check("viol_cnt", 64'(cnt_lsb), 64'd0);
        check("viol_novalid", 64'(valid_lsb), 64'd0);
        tick();
        check("viol_serr_1cyc", 64'(serr_lsb), 64'd0);
`else
        strobe(1'b1);
        check("ones7_serr", 64'(serr_lsb), 64'd0);
        check("ones7_cnt", 64'(cnt_lsb), 64'd7);
        strobe(1'b1);
        check_both("ones8", 8'hFF, 8'hFF);
`endif
        send_word(8'h00);
        check_both("zeros", 8'h00, 8'h00);
        tick();
        check("zeros_drained", 64'(valid_lsb), 64'd0);

        // Holding register blocked: second word must be dropped.
        data_ready = 1'b0;
        send_word(8'hA5);
        check_both("ovf_first", 8'hA5, 8'hA5);
        check("ovf_none_yet", 64'(ovf_lsb), 64'd0);
        send_word(8'h3C);
        check_both("ovf_hold", 8'hA5, 8'hA5);
        check("ovf_set", 64'(ovf_lsb), 64'd1);
        check("ovf_set_msb", 64'(ovf_msb), 64'd1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("ovf_drain_valid", 64'(valid_lsb), 64'd0);
        check("ovf_sticky", 64'(ovf_lsb), 64'd1);
        pulse_clear();
        check("ovf_cleared", 64'(ovf_lsb), 64'd0);

        data_ready = 1'b1;
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        check("mid_cnt5", 64'(cnt_lsb), 64'd5);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_cnt", 64'(cnt_lsb), 64'd0);
        check("mid_rst_data", 64'(data_lsb), 64'd0);
        send_word(8'h96);
        check_both("after_rst", 8'h96, 8'h69);

        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        check("clr_cnt5", 64'(cnt_lsb), 64'd5);
        clear        = 1'b1;
        shift_enable = 1'b1;
        serial_in    = 1'b1;
        tick();
        clear        = 1'b0;
        shift_enable = 1'b0;
        check("clr_cnt0", 64'(cnt_lsb), 64'd0);
        check("clr_cnt0_msb", 64'(cnt_msb), 64'd0);
        send_word(8'h35);
        check_both("after_clr", 8'h35, 8'hAC);
        check("after_clr_ovf", 64'(ovf_lsb), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
